// File: rtl/puf_key_sequencer.sv
// puf_key_sequencer
//   Drives a ring-oscillator PUF core one challenge at a time. Each key bit
//   uses a settle / measure / hold window. The resulting response bits are
//   shifted into a key, which is then offered on a valid/ready output.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      request a key generation (sampled only in IDLE)
//   seed[7:0]  base challenge, captured when start is accepted
//   busy       high whenever the sequencer is not IDLE
//   ro_en      oscillator enable to the PUF core
//   challenge  challenge to the PUF core (base + bit index, wraps mod 256)
//   response   PUF response bit, asynchronous to clk
//   key_data   assembled key, bit i = response to challenge i
//   key_valid  key_data complete and stable
//   key_ready  consumer accepts the key
module puf_key_sequencer #(
  parameter int N_BITS = 32,
  parameter int SETTLE = 4,
  parameter int WINDOW = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              ro_en,
  output logic [7:0]        challenge,
  input  logic              response,
  output logic [N_BITS-1:0] key_data,
  output logic              key_valid,
  input  logic              key_ready
);

  // The counter also times the 3-cycle HOLD phase, so it must reach 2 even
  // when SETTLE and WINDOW are tiny.
  localparam int MAX_A = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int MAX_C = (MAX_A > 3) ? MAX_A : 3;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam int IW    = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [IW-1:0]     index_reg;
  logic [7:0]        base_reg;
  logic              sync_meta_reg;
  logic [N_BITS-1:0] key_data_reg;

  logic start_accept;
  logic settle_done;
  logic measure_done;
  logic hold_done;
  logic last_bit;

  assign start_accept = (state_reg == ST_IDLE) && start;
  assign settle_done  = (state_reg == ST_SETTLE)  && (cnt_reg == CW'(SETTLE - 1));
  assign measure_done = (state_reg == ST_MEASURE) && (cnt_reg == CW'(WINDOW - 1));
  assign hold_done    = (state_reg == ST_HOLD)    && (cnt_reg == CW'(2));
  assign last_bit     = (index_reg == IW'(N_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_accept) state_next = ST_SETTLE;
      ST_SETTLE:  if (settle_done)  state_next = ST_MEASURE;
      ST_MEASURE: if (measure_done) state_next = ST_HOLD;
      ST_HOLD:    if (hold_done)    state_next = last_bit ? ST_OUTPUT : ST_SETTLE;
      ST_OUTPUT:  if (key_ready)    state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded straight from the state so that ro_en and the
  // handshake flags drop the moment rst_n is asserted.
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    ro_en     = (state_reg == ST_MEASURE);
    key_valid = (state_reg == ST_OUTPUT);
    challenge = base_reg + 8'(index_reg);
  end

  // Phase counter: restarts at every phase boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if ((state_reg == ST_IDLE) || (state_reg == ST_OUTPUT) ||
                 settle_done || measure_done || hold_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Base challenge and bit index. The index only advances at HOLD->SETTLE,
  // so the challenge is constant across a bit's whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg  <= 8'h00;
      index_reg <= '0;
    end else if (start_accept) begin
      base_reg  <= seed;
      index_reg <= '0;
    end else if (hold_done && !last_bit) begin
      index_reg <= index_reg + IW'(1);
    end
  end

  // First synchroniser stage runs continuously. The key bit register is the
  // second stage: on the third HOLD edge it takes the value sampled on the
  // second HOLD edge, i.e. two cycles after the oscillator was frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b0;
    end else begin
      sync_meta_reg <= response;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_key_bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          key_data_reg[gi] <= 1'b0;
        end else if (start_accept) begin
          key_data_reg[gi] <= 1'b0;
        end else if (hold_done && (index_reg == IW'(gi))) begin
          key_data_reg[gi] <= sync_meta_reg;
        end
      end
    end
  endgenerate

  assign key_data = key_data_reg;

endmodule

// File: tb/tb_puf_key_sequencer.sv
module tb_puf_key_sequencer;

  localparam int NB = 4;
  localparam int S  = 2;
  localparam int W  = 8;
  localparam int P  = S + W + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    seed;
  logic          busy;
  logic          ro_en;
  logic [7:0]    challenge;
  logic          response;
  logic [NB-1:0] key_data;
  logic          key_valid;
  logic          key_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  puf_key_sequencer #(.N_BITS(NB), .SETTLE(S), .WINDOW(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .ro_en     (ro_en),
    .challenge (challenge),
    .response  (response),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  typedef struct {
    logic [7:0]       seed;
    logic [3:0][7:0]  ch;       // expected challenge per bit, [0] first
    logic [3:0]       key;      // expected key_data
    int               ready_delay;
    bit               glitch;   // pulse start with another seed in MEASURE
    bit               sync_mode;// toggle response in MEASURE, settle in HOLD
    bit               invert;   // response = ~challenge[0]
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int i, cp;
    logic d;
    @(negedge clk);
    start     = 1'b1;
    seed      = v.seed;
    key_ready = (v.ready_delay == 0);
    @(posedge clk);          // edge T
    #1;
    start = 1'b0;
    seed  = 8'h00;
    check("accept_key_clear", 64'(key_data), 64'd0);
    for (int c = 0; c < NB * P; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      i  = c / P;
      cp = c % P;
      check("busy",      64'(busy),      64'd1);
      check("challenge", 64'(challenge), 64'(v.ch[i]));
      check("ro_en",     64'(ro_en),     64'((cp >= S) && (cp < S + W)));
      check("key_valid_early", 64'(key_valid), 64'd0);
      d = v.ch[i][0] ^ v.invert;
      if (v.sync_mode && cp >= S && cp < S + W) response = c[0];
      else if (v.sync_mode && cp == S + W)      response = ~d;
      else                                      response = d;
      if (v.glitch && c == P + S + 2) begin
        start = 1'b1;
        seed  = 8'hAA;
      end else begin
        start = 1'b0;
        seed  = 8'h00;
      end
    end
    @(posedge clk);          // edge T + NB*P
    #1;
    check("key_valid_rise", 64'(key_valid), 64'd1);
    check("key_data",       64'(key_data),  64'(v.key));
    for (int k = 0; k < v.ready_delay; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(key_valid), 64'd1);
      check("bp_data",  64'(key_data),  64'(v.key));
    end
    key_ready = 1'b1;
    @(posedge clk);          // handshake edge
    #1;
    check("post_hs_valid", 64'(key_valid), 64'd0);
    check("post_hs_busy",  64'(busy),      64'd0);
    check("post_hs_data",  64'(key_data),  64'(v.key));
    $display("vec %0d seed=%02h key=%b valid_cycles=%0d", vi, v.seed, key_data, v.ready_delay + 1);
  endtask

  initial begin
    vecs[0] = '{8'h10, {8'h13, 8'h12, 8'h11, 8'h10}, 4'b1010, 0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFE, {8'h01, 8'h00, 8'hFF, 8'hFE}, 4'b1010, 20, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h01, {8'h04, 8'h03, 8'h02, 8'h01}, 4'b0101, 0,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, {8'h82, 8'h81, 8'h80, 8'h7F}, 4'b1010, 0,  1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; seed = 8'h00; response = 1'b0; key_ready = 1'b0;
    #1;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_ro_en",     64'(ro_en),     64'd0);
    check("rst_challenge", 64'(challenge), 64'h00);
    check("rst_valid",     64'(key_valid), 64'd0);
    check("rst_key",       64'(key_data),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of MEASURE: everything drops without a clock edge.
    @(negedge clk);
    start = 1'b1;
    seed  = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    check("mid_ro_en_high", 64'(ro_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ro_en",     64'(ro_en),     64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_challenge", 64'(challenge), 64'h00);
    check("mid_rst_valid",     64'(key_valid), 64'd0);
    check("mid_rst_key",       64'(key_data),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_busy", 64'(busy), 64'd0);
    $display("mid-measure reset: busy=%0d ro_en=%0d", busy, ro_en);

    // Back-to-back runs: each new start follows the previous handshake edge.
    for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
